// File: rtl/countdown_timer_ctrl_if.sv
// countdown_timer_ctrl_if: button/tick inputs and BCD display/status outputs of the countdown timer.
interface countdown_timer_ctrl_if;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic       set_en;
    logic       inc_min;
    logic       inc_sec;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic       running;
    logic       done;
    logic [1:0] state;

    modport master (
        output tick, start_stop, clear, set_en, inc_min, inc_sec,
        input  min_t, min_u, sec_t, sec_u, running, done, state
    );

    modport slave (
        input  tick, start_stop, clear, set_en, inc_min, inc_sec,
        output min_t, min_u, sec_t, sec_u, running, done, state
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: MM:SS BCD countdown with run/pause/done FSM and a preset editable in IDLE.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset at 00:00 and pulse done instead of stopping.
module countdown_timer_ctrl #(
    parameter logic [3:0] INIT_MIN_T = 4'd0,
    parameter logic [3:0] INIT_MIN_U = 4'd1,
    parameter logic [3:0] INIT_SEC_T = 4'd3,
    parameter logic [3:0] INIT_SEC_U = 4'd0
) (
    input logic clk,
    input logic rst,
    countdown_timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [15:0] INIT = {INIT_MIN_T, INIT_MIN_U, INIT_SEC_T, INIT_SEC_U};

    state_t      state_q, state_n;
    logic [15:0] disp_q, disp_n, preset_q, preset_n, dec;
    logic        running_q, done_q, done_n, su0, st0, mu0, zero, last;

    // Wrapping 00..59 increment of a two-digit BCD field.
    function automatic logic [7:0] inc59(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? ((v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                                : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign su0  = disp_q[3:0] == 4'd0;
    assign st0  = disp_q[7:4] == 4'd0;
    assign mu0  = disp_q[11:8] == 4'd0;
    assign zero = disp_q == 16'h0000;
    assign last = disp_q == 16'h0001;

    assign dec[3:0]   = su0 ? 4'd9 : disp_q[3:0] - 4'd1;
    assign dec[7:4]   = su0 ? (st0 ? 4'd5 : disp_q[7:4] - 4'd1) : disp_q[7:4];
    assign dec[11:8]  = (su0 && st0) ? (mu0 ? 4'd9 : disp_q[11:8] - 4'd1) : disp_q[11:8];
    assign dec[15:12] = (su0 && st0 && mu0) ? disp_q[15:12] - 4'd1 : disp_q[15:12];

    always_comb begin
        state_n  = state_q;
        disp_n   = disp_q;
        preset_n = preset_q;
        done_n   = 1'b0;
        if (bus.clear) begin
            state_n = IDLE;
            disp_n  = preset_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.set_en) begin
                        if (bus.inc_sec) preset_n[7:0] = inc59(preset_q[7:0]);
                        if (bus.inc_min) preset_n[15:8] = inc59(preset_q[15:8]);
                        disp_n = preset_n;
                    end
                    if (bus.start_stop && !zero) state_n = RUN;
                end
                RUN: begin
                    if (bus.tick && last) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        disp_n = preset_q;
                        done_n = 1'b1;
                        if (bus.start_stop) state_n = PAUSE;
`else
                        disp_n  = dec;
                        state_n = DONE;
`endif
                    end else begin
                        if (bus.tick && !zero) disp_n = dec;
                        if (bus.start_stop) state_n = PAUSE;
                    end
                end
                PAUSE: if (bus.start_stop) state_n = RUN;
                default: begin
                    if (bus.start_stop) begin
                        state_n = IDLE;
                        disp_n  = preset_q;
                    end
                end
            endcase
        end
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        done_n = state_n == DONE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            disp_q    <= INIT;
            preset_q  <= INIT;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            disp_q    <= disp_n;
            preset_q  <= preset_n;
            running_q <= state_n == RUN;
            done_q    <= done_n;
        end
    end

    assign {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u} = disp_q;
    assign bus.state   = state_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed checks of counting, pause, done, preset editing and clear priority.
module tb_countdown_timer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    countdown_timer_ctrl_if bus ();
    countdown_timer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step(input logic t, input logic ss, input logic clr, input logic is, input logic im);
        bus.tick = t;
        bus.start_stop = ss;
        bus.clear = clr;
        bus.inc_sec = is;
        bus.inc_min = im;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
        bus.inc_sec = 1'b0;
        bus.inc_min = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic incs(input int ns, input int nm);
        for (int i = 0; i < ns; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < nm; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Observed vector: {mm:ss BCD, state, running, done}.
    task automatic check(input string tag, input logic [15:0] d, input logic [1:0] s, input logic r, input logic dn);
        logic [19:0] obs;
        logic [19:0] exp;
        obs = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u, bus.state, bus.running, bus.done};
        exp = {d, s, r, dn};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h st=%0d run=%b done=%b, expected %h st=%0d run=%b done=%b",
                   tag, obs[19:4], obs[3:2], obs[1], obs[0], exp[19:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
        bus.set_en = 1'b0;
        bus.inc_sec = 1'b0;
        bus.inc_min = 1'b0;
        #2 rst = 1'b1;
        #1 check("reset_async", 16'h0130, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("reset_hold", 16'h0130, 2'd0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start", 16'h0130, 2'd1, 1'b1, 1'b0);
        ticks(3);
        check("three_ticks", 16'h0127, 2'd1, 1'b1, 1'b0);
        ticks(27);
        check("at_0100", 16'h0100, 2'd1, 1'b1, 1'b0);
        ticks(1);
        check("double_borrow", 16'h0059, 2'd1, 1'b1, 1'b0);
        ticks(54);
        check("at_0005", 16'h0005, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_with_tick", 16'h0004, 2'd2, 1'b0, 1'b0);
        ticks(3);
        check("pause_frozen", 16'h0004, 2'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("resume", 16'h0004, 2'd1, 1'b1, 1'b0);
        ticks(2);
        check("at_0002", 16'h0002, 2'd1, 1'b1, 1'b0);
        ticks(2);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        check("reload_first", 16'h0130, 2'd1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reload_pulse_end", 16'h0130, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_run", 16'h0130, 2'd0, 1'b0, 1'b0);
`else
        check("done", 16'h0000, 2'd3, 1'b0, 1'b1);
        ticks(1);
        check("done_hold", 16'h0000, 2'd3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("done_ack", 16'h0130, 2'd0, 1'b0, 1'b0);
`endif

        bus.set_en = 1'b1;
        incs(28, 0);
        check("preset_0158", 16'h0158, 2'd0, 1'b0, 1'b0);
        incs(0, 58);
        check("preset_5958", 16'h5958, 2'd0, 1'b0, 1'b0);
        incs(0, 1);
        check("min_wrap", 16'h0058, 2'd0, 1'b0, 1'b0);
        incs(2, 0);
        check("sec_wrap_no_carry", 16'h0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_blocked_zero", 16'h0000, 2'd0, 1'b0, 1'b0);
        bus.set_en = 1'b0;
        incs(1, 1);
        check("inc_no_set_en", 16'h0000, 2'd0, 1'b0, 1'b0);
        bus.set_en = 1'b1;
        incs(1, 0);
        check("preset_0001", 16'h0001, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clear_beats_inc", 16'h0001, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("inc_both", 16'h0102, 2'd0, 1'b0, 1'b0);
        bus.set_en = 1'b0;

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check("run_0101", 16'h0101, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clear_priority", 16'h0102, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        rst = 1'b1;
        #1 check("reset_mid_run", 16'h0130, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        bus.set_en = 1'b1;
        incs(32, 59);
        check("preset_0002", 16'h0002, 2'd0, 1'b0, 1'b0);
        bus.set_en = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check("run_0001", 16'h0001, 2'd1, 1'b1, 1'b0);
        ticks(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        check("reload_0002", 16'h0002, 2'd1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reload_done_one_cycle", 16'h0002, 2'd1, 1'b1, 1'b0);
`else
        check("done_0002", 16'h0000, 2'd3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_done", 16'h0002, 2'd0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- MM:SS countdown timer controller built from four chained BCD down-counting digits: sec units (limit 9), sec tens (5), min units (9), min tens (5).
- Sequences the digit chain: issues decrements on an external 1-cycle tick, gates them with a run/pause/done FSM, and lets the user edit a preset while idle.
- Sits between the debounced/one-pulsed buttons plus the tick divider on one side and the 7-segment scan driver on the other.

Parameters:
- INIT_MIN_T, 4'd0, reset preset for minute tens; legal BCD 0-5, not checked.
- INIT_MIN_U, 4'd1, reset preset for minute units; 0-9.
- INIT_SEC_T, 4'd3, reset preset for second tens; 0-5.
- INIT_SEC_U, 4'd0, reset preset for second units; 0-9.

Ports:
- clk  input  1  global clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  1-cycle decrement enable, typically 1 Hz.
- start_stop  input  1  1-cycle pulse: start, pause, resume or acknowledge.
- clear  input  1  1-cycle pulse: abort and reload preset.
- set_en  input  1  level; enables preset editing in IDLE.
- inc_min  input  1  1-cycle pulse: preset minutes +1.
- inc_sec  input  1  1-cycle pulse: preset seconds +1.
- min_t, min_u, sec_t, sec_u  output  4 each  displayed BCD digits, registered.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset, asynchronous: preset <= INIT_* params; display <= INIT_* params; state = IDLE; running = 0; done = 0.
- All outputs are registered. Every response takes effect on the first clk edge after the input is sampled high.
- Decrement, applied only when state == RUN and tick == 1:
  - sec_u 0 -> 9 with borrow into sec_t, else sec_u - 1.
  - sec_t 0 -> 5 with borrow into min_u.
  - min_u 0 -> 9 with borrow into min_t.
  - min_t decrements on borrow.
  - Decrement from 00:00 never happens: the display does not wrap.
- Input priority per cycle: clear > tick > start_stop. clear from any state: state = IDLE, display <= preset, pending tick ignored.
- IDLE:
  - start_stop with display != 00:00 -> RUN.
  - start_stop with display == 00:00 is ignored.
  - With set_en = 1: inc_sec moves preset seconds 00..59 and wraps 59 -> 00 with no carry into minutes; inc_min moves preset minutes 00..59 and wraps 59 -> 00.
  - inc_sec and inc_min in the same cycle: both apply. Display tracks preset in the same edge.
  - inc_* while set_en = 0, or in any other state: ignored.
- RUN:
  - Tick taking display 00:01 -> 00:00 moves to DONE on the same edge, even if start_stop is also high.
  - Otherwise start_stop -> PAUSE. If a tick arrives in the same cycle, the decrement is still applied.
- PAUSE: display frozen, ticks ignored; start_stop -> RUN.
- DONE: display holds 00:00, done = 1. start_stop -> IDLE with display <= preset; clear does the same.
- Preset is never altered by counting. Reset mid-run returns to the parameter preset, not the edited preset.

Optional Feature:
- Macro COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - In RUN, the tick reaching 00:00 loads display <= preset and stays in RUN; DONE is unreachable.
  - done pulses high for exactly one cycle, the cycle after the reload edge.
  - A preset of 00:00 stays blocked at start.
- Undefined: the base DONE behaviour above applies.

Test Plan:
- Reset with defaults -> display 01:30, state 0, running 0, done 0.
- start_stop, then 3 ticks -> RUN, display 01:27; a tick at 01:00 -> 00:59 (borrow across both tens digits).
- In RUN at 00:05, start_stop and tick in the same cycle -> 00:04 and PAUSE; further ticks hold 00:04; start_stop resumes RUN.
- From 00:02 in RUN, 2 ticks -> 00:00, state DONE, done 1, running 0; start_stop -> IDLE, display 01:30.
- IDLE, set_en = 1, preset 00:58: 2 inc_sec -> 00:00 with minutes unchanged; start_stop is ignored; inc_min to 59 then one more -> 00:00; clear in the same cycle as inc_sec -> clear wins.
- With COUNTDOWN_AUTO_RELOAD_EN and preset 00:02: 2 ticks -> display 00:02, still RUN, done high exactly one cycle.
